// File: rtl/exu_div_pkg.sv
// Shared types and constants for the EXU iterative divider.
// Optional result cache is enabled with `define DIV_RESULT_CACHE_EN.
package exu_div_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned TAG_W       = 32;
   localparam int unsigned RD_W        = 5;
   localparam int unsigned CNT_W       = $clog2(XLEN);
   localparam int unsigned DIV_LATENCY = XLEN + 2;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

   typedef struct packed {
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic             unsign;
      logic             rem;
      logic [RD_W-1:0]  rd_addr;
      logic [TAG_W-1:0] instr_tag;
   } div_req_t;

   // Magnitude of an operand; unsigned operands pass through untouched.
   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic unsign);
      return (!unsign && x[XLEN-1]) ? XLEN'(-x) : x;
   endfunction

endpackage

// File: rtl/exu_div_if.sv
// Issue-side request bundle and writeback result bundle of the divider.
interface exu_div_if;
   import exu_div_pkg::*;

   logic             div_start;
   logic [XLEN-1:0]  div_rs1;
   logic [XLEN-1:0]  div_rs2;
   logic             div_unsign;
   logic             div_rem;
   logic [RD_W-1:0]  div_rd_addr;
   logic [TAG_W-1:0] div_instr_tag;
   logic             div_busy;
   logic             wb_valid;
   logic [XLEN-1:0]  wb_data;
   logic [RD_W-1:0]  wb_rd_addr;
   logic [TAG_W-1:0] wb_instr_tag;

   modport master (
      output div_start, div_rs1, div_rs2, div_unsign, div_rem, div_rd_addr, div_instr_tag,
      input  div_busy, wb_valid, wb_data, wb_rd_addr, wb_instr_tag
   );

   modport slave (
      input  div_start, div_rs1, div_rs2, div_unsign, div_rem, div_rd_addr, div_instr_tag,
      output div_busy, wb_valid, wb_data, wb_rd_addr, wb_instr_tag
   );

endinterface

// File: rtl/exu_div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract, restore on borrow.
module exu_div_step
   import exu_div_pkg::*;
(
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quot_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN:0]   rem_next_c_o,
   output logic [XLEN-1:0] quot_next_c_o
);

   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;
   logic            borrow;

   always_comb begin
      shifted       = {rem_i, quot_i[XLEN-1]};
      diff          = shifted - {2'b00, divisor_i};
      borrow        = diff[XLEN+1];
      rem_next_c_o  = borrow ? shifted[XLEN:0] : diff[XLEN:0];
      quot_next_c_o = {quot_i[XLEN-2:0], ~borrow};
   end

endmodule

// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider (RISC-V DIV/DIVU/REM/REMU) with one-shot writeback.
// `define DIV_RESULT_CACHE_EN adds a single-entry result cache for back-to-back DIV/REM pairs.
module exu_div
   import exu_div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   exu_div_if.slave div_if
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN:0]    rem_q, rem_d;
   logic [XLEN-1:0]  quot_q, quot_d, dvsr_q, dvsr_d;
   logic             neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
   logic             rem_sel_q, rem_sel_d;
   logic [RD_W-1:0]  rd_q, rd_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             busy_q, busy_d, wb_valid_q, wb_valid_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
   logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

   div_req_t         req_c;
   logic             div_zero_c, ovf_c;
   logic [XLEN:0]    rem_step_c;
   logic [XLEN-1:0]  quot_step_c, quot_fix_c, rem_fix_c;

`ifdef DIV_RESULT_CACHE_EN
   logic             c_vld_q, c_vld_d, c_uns_q, c_uns_d, key_uns_q, key_uns_d;
   logic [XLEN-1:0]  c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quot_q, c_quot_d, c_rem_q, c_rem_d;
   logic [XLEN-1:0]  key_rs1_q, key_rs1_d, key_rs2_q, key_rs2_d;
   logic             hit_c;
`endif

   assign req_c = '{rs1: div_if.div_rs1, rs2: div_if.div_rs2, unsign: div_if.div_unsign,
                    rem: div_if.div_rem, rd_addr: div_if.div_rd_addr,
                    instr_tag: div_if.div_instr_tag};

   exu_div_step u_step (
      .rem_i         (rem_q),
      .quot_i        (quot_q),
      .divisor_i     (dvsr_q),
      .rem_next_c_o  (rem_step_c),
      .quot_next_c_o (quot_step_c)
   );

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      rem_sel_d  = rem_sel_q;
      rd_d       = rd_q;
      tag_d      = tag_q;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_tag_d   = wb_tag_q;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_d    = c_vld_q;
      c_uns_d    = c_uns_q;
      c_rs1_d    = c_rs1_q;
      c_rs2_d    = c_rs2_q;
      c_quot_d   = c_quot_q;
      c_rem_d    = c_rem_q;
      key_uns_d  = key_uns_q;
      key_rs1_d  = key_rs1_q;
      key_rs2_d  = key_rs2_q;
      hit_c      = c_vld_q && (req_c.rs1 == c_rs1_q) && (req_c.rs2 == c_rs2_q)
                   && (req_c.unsign == c_uns_q);
`endif
      div_zero_c = (req_c.rs2 == '0);
      ovf_c      = !req_c.unsign && (req_c.rs1 == INT_MIN) && (req_c.rs2 == '1);
      quot_fix_c = neg_quot_q ? XLEN'(-quot_q) : quot_q;
      rem_fix_c  = neg_rem_q ? XLEN'(-rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

      case (state_q)
         IDLE: begin
            if (div_if.div_start) begin
               rem_sel_d = req_c.rem;
               rd_d      = req_c.rd_addr;
               tag_d     = req_c.instr_tag;
               if (div_zero_c) begin
                  wb_data_d = req_c.rem ? req_c.rs1 : '1;
                  wb_rd_d   = req_c.rd_addr;
                  wb_tag_d  = req_c.instr_tag;
                  state_d   = DONE;
               end else if (ovf_c) begin
                  wb_data_d = req_c.rem ? '0 : INT_MIN;
                  wb_rd_d   = req_c.rd_addr;
                  wb_tag_d  = req_c.instr_tag;
                  state_d   = DONE;
`ifdef DIV_RESULT_CACHE_EN
               end else if (hit_c) begin
                  wb_data_d = req_c.rem ? c_rem_q : c_quot_q;
                  wb_rd_d   = req_c.rd_addr;
                  wb_tag_d  = req_c.instr_tag;
                  state_d   = DONE;
`endif
               end else begin
                  quot_d     = abs_val(req_c.rs1, req_c.unsign);
                  dvsr_d     = abs_val(req_c.rs2, req_c.unsign);
                  rem_d      = '0;
                  neg_quot_d = !req_c.unsign && (req_c.rs1[XLEN-1] ^ req_c.rs2[XLEN-1]);
                  neg_rem_d  = !req_c.unsign && req_c.rs1[XLEN-1];
                  cnt_d      = '0;
`ifdef DIV_RESULT_CACHE_EN
                  key_rs1_d  = req_c.rs1;
                  key_rs2_d  = req_c.rs2;
                  key_uns_d  = req_c.unsign;
`endif
                  state_d    = CALC;
               end
            end
         end
         CALC: begin
            rem_d  = rem_step_c;
            quot_d = quot_step_c;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            wb_data_d = rem_sel_q ? rem_fix_c : quot_fix_c;
            wb_rd_d   = rd_q;
            wb_tag_d  = tag_q;
`ifdef DIV_RESULT_CACHE_EN
            c_vld_d   = 1'b1;
            c_rs1_d   = key_rs1_q;
            c_rs2_d   = key_rs2_q;
            c_uns_d   = key_uns_q;
            c_quot_d  = quot_fix_c;
            c_rem_d   = rem_fix_c;
`endif
            state_d   = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d == CALC) || (state_d == FIX);
      wb_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvsr_q     <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         rem_sel_q  <= 1'b0;
         rd_q       <= '0;
         tag_q      <= '0;
         busy_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_tag_q   <= '0;
`ifdef DIV_RESULT_CACHE_EN
         c_vld_q    <= 1'b0;
         c_uns_q    <= 1'b0;
         c_rs1_q    <= '0;
         c_rs2_q    <= '0;
         c_quot_q   <= '0;
         c_rem_q    <= '0;
         key_uns_q  <= 1'b0;
         key_rs1_q  <= '0;
         key_rs2_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         dvsr_q     <= dvsr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         rem_sel_q  <= rem_sel_d;
         rd_q       <= rd_d;
         tag_q      <= tag_d;
         busy_q     <= busy_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_tag_q   <= wb_tag_d;
`ifdef DIV_RESULT_CACHE_EN
         c_vld_q    <= c_vld_d;
         c_uns_q    <= c_uns_d;
         c_rs1_q    <= c_rs1_d;
         c_rs2_q    <= c_rs2_d;
         c_quot_q   <= c_quot_d;
         c_rem_q    <= c_rem_d;
         key_uns_q  <= key_uns_d;
         key_rs1_q  <= key_rs1_d;
         key_rs2_q  <= key_rs2_d;
`endif
      end
   end

   assign div_if.div_busy     = busy_q;
   assign div_if.wb_valid     = wb_valid_q;
   assign div_if.wb_data      = wb_data_q;
   assign div_if.wb_rd_addr   = wb_rd_q;
   assign div_if.wb_instr_tag = wb_tag_q;

   // Issue must never strobe while a divide or its writeback is in flight
   a_no_start_when_busy: assert property (@(posedge clk) disable iff (rst)
      !(div_if.div_start && (state_q != IDLE)))
      else $error("exu_div: div_start received while not IDLE");

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: directed cases plus randomized operands against an arithmetic model.
module tb_exu_div;
   import exu_div_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exu_div_if dif ();

   exu_div dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model of the single-entry result cache (only consulted when the feature is built in)
   logic        m_vld = 1'b0;
   logic [31:0] m_rs1 = '0;
   logic [31:0] m_rs2 = '0;
   logic        m_uns = 1'b0;
   logic [31:0] prev_a = 32'd1;
   logic [31:0] prev_b = 32'd1;
   logic        prev_u = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns, input logic rem);
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      if (uns) return rem ? (a % b) : (a / b);
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
   endfunction

   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic rem, output logic [31:0] got);
      logic [31:0] exp;
      logic [4:0]  rd;
      logic [31:0] tg;
      logic        special, hit;
      int          exp_lat, lat, busy_n;
      exp     = ref_div(a, b, uns, rem);
      rd      = 5'($urandom_range(0, 31));
      tg      = $urandom;
      special = (b == 32'd0) || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      hit     = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      hit     = m_vld && (a == m_rs1) && (b == m_rs2) && (uns == m_uns);
`endif
      exp_lat = (special || hit) ? 1 : int'(DIV_LATENCY);
      lat     = 0;
      busy_n  = 0;
      got     = 'x;

      @(negedge clk);
      dif.div_start     = 1'b1;
      dif.div_rs1       = a;
      dif.div_rs2       = b;
      dif.div_unsign    = uns;
      dif.div_rem       = rem;
      dif.div_rd_addr   = rd;
      dif.div_instr_tag = tg;
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (dif.wb_valid) begin
            lat = k;
            break;
         end
         if (dif.div_busy) busy_n++;
      end
      got = dif.wb_data;
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_data"}, 64'(dif.wb_data), 64'(exp));
      check({name, "_rd"}, 64'(dif.wb_rd_addr), 64'(rd));
      check({name, "_tag"}, 64'(dif.wb_instr_tag), 64'(tg));
      check({name, "_busy_at_wb"}, 64'(dif.div_busy), 64'd0);
      check({name, "_busy_cycles"}, 64'(busy_n), 64'((exp_lat == 1) ? 0 : int'(DIV_LATENCY) - 1));
      @(posedge clk);
      #1;
      check({name, "_wb_pulse"}, 64'(dif.wb_valid), 64'd0);
      check({name, "_wb_hold"}, 64'(dif.wb_data), 64'(exp));
      if (!special && !hit) begin
         m_vld = 1'b1;
         m_rs1 = a;
         m_rs2 = b;
         m_uns = uns;
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] a, b;
      logic        u;
      int          n_wb;

      rst               = 1'b1;
      dif.div_start     = 1'b0;
      dif.div_rs1       = '0;
      dif.div_rs2       = '0;
      dif.div_unsign    = 1'b0;
      dif.div_rem       = 1'b0;
      dif.div_rd_addr   = '0;
      dif.div_instr_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(dif.div_busy), 64'd0);
      check("reset_wb_valid", 64'(dif.wb_valid), 64'd0);
      check("reset_wb_data", 64'(dif.wb_data), 64'd0);
      check("reset_wb_rd", 64'(dif.wb_rd_addr), 64'd0);
      check("reset_wb_tag", 64'(dif.wb_instr_tag), 64'd0);
      check("reset_state", 64'(dut.state_q), 64'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      run_div("div_neg20_3", 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0, r);
      check("tp_div_neg20_3", 64'(r), 64'hFFFF_FFFA);
      run_div("rem_neg20_3", 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1, r);
      check("tp_rem_neg20_3", 64'(r), 64'hFFFF_FFFE);
      run_div("divu_big", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0, r);
      check("tp_divu_big", 64'(r), 64'h0FFF_FFFF);
      run_div("remu_big", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1, r);
      check("tp_remu_big", 64'(r), 64'hF);
      run_div("div_by_zero", 32'd7, 32'd0, 1'b0, 1'b0, r);
      check("tp_div_by_zero", 64'(r), 64'hFFFF_FFFF);
      run_div("rem_by_zero", 32'd7, 32'd0, 1'b0, 1'b1, r);
      check("tp_rem_by_zero", 64'(r), 64'd7);
      run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, r);
      check("tp_div_ovf", 64'(r), 64'h8000_0000);
      run_div("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, r);
      check("tp_rem_ovf", 64'(r), 64'd0);

      // Abort a divide with reset ten cycles into it
      @(negedge clk);
      dif.div_start   = 1'b1;
      dif.div_rs1     = 32'd12345;
      dif.div_rs2     = 32'd17;
      dif.div_unsign  = 1'b0;
      dif.div_rem     = 1'b0;
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      m_vld = 1'b0;
      check("abort_busy", 64'(dif.div_busy), 64'd0);
      check("abort_wb_valid", 64'(dif.wb_valid), 64'd0);
      check("abort_state", 64'(dut.state_q), 64'(IDLE));
      n_wb = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (dif.wb_valid) n_wb++;
      end
      check("abort_no_wb", 64'(n_wb), 64'd0);

      run_div("div_100_7", 32'd100, 32'd7, 1'b0, 1'b0, r);
      check("tp_div_100_7", 64'(r), 64'd14);
      run_div("rem_100_7", 32'd100, 32'd7, 1'b0, 1'b1, r);
      check("tp_rem_100_7", 64'(r), 64'd2);

      for (int i = 0; i < 40; i++) begin
         int mode;
         mode = int'($urandom_range(0, 9));
         u    = 1'($urandom_range(0, 1));
         a    = $urandom;
         b    = $urandom;
         case (mode)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; u = 1'b0; end
            2, 3: begin a = prev_a; b = prev_b; u = prev_u; end
            4: b = 32'($urandom_range(1, 20));
            5: begin a = 32'h8000_0000; b = 32'($urandom_range(1, 9)); end
            default: ;
         endcase
         prev_a = a;
         prev_b = b;
         prev_u = u;
         run_div($sformatf("rand%0d", i), a, b, u, 1'($urandom_range(0, 1)), r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
